// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: channel 0 has fixed priority, channels 1..NUM_CH-1 share
// the remaining slots round-robin with a starvation guard; per-channel read capture.

module vram_arbiter_rd_lane #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset_i,
   input  logic              rd_grant_i,
   input  logic [DATA_W-1:0] mem_data_i,
   output logic              rd_valid_o,
   output logic [DATA_W-1:0] rd_data_o
);
   logic              rd_pend_q, rd_pend_d;
   logic [DATA_W-1:0] hold_q, hold_d;

   always_comb begin
      rd_pend_d  = rd_grant_i;
      hold_d     = rd_pend_q ? mem_data_i : hold_q;
      rd_valid_o = rd_pend_q;
      // Fresh data bypasses the capture register on its return cycle
      rd_data_o  = rd_pend_q ? mem_data_i : hold_q;
   end

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         rd_pend_q <= 1'b0;
         hold_q    <= '0;
      end else begin
         rd_pend_q <= rd_pend_d;
         hold_q    <= hold_d;
      end
   end
endmodule

module vram_arbiter #(
   parameter int NUM_CH       = 4,
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 16,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                       clk,
   input  logic                       reset_i,
   input  logic [NUM_CH-1:0]          req_sel_i,
   input  logic [NUM_CH-1:0]          req_wr_i,
   input  logic [NUM_CH*DATA_W/4-1:0] req_mask_i,
   input  logic [NUM_CH*ADDR_W-1:0]   req_addr_i,
   input  logic [NUM_CH*DATA_W-1:0]   req_data_i,
   output logic [NUM_CH-1:0]          ack_o,
   output logic [NUM_CH-1:0]          rd_valid_o,
   output logic [NUM_CH*DATA_W-1:0]   rd_data_o,
   output logic                       mem_sel_o,
   output logic                       mem_wr_o,
   output logic [DATA_W/4-1:0]        mem_mask_o,
   output logic [ADDR_W-1:0]          mem_addr_o,
   output logic [DATA_W-1:0]          mem_data_o,
   input  logic [DATA_W-1:0]          mem_data_i
);
   localparam int MASK_W = DATA_W / 4;
   localparam int PTR_W  = $clog2(NUM_CH);
   localparam int CNT_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

   logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d, rr_win;
   logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
   logic              rr_found, rr_gnt, ch0_gnt, starve_hit;
   logic [NUM_CH-1:0] gnt;

   // Round-robin search over channels 1..NUM_CH-1, starting just after rr_ptr
   always_comb begin
      int cand;
      cand     = 0;
      rr_found = 1'b0;
      rr_win   = '0;
      for (int off = 1; off < NUM_CH; off++) begin
         cand = int'(rr_ptr_q) + off;
         if (cand > NUM_CH - 1) cand = cand - (NUM_CH - 1);
         if (!rr_found && req_sel_i[cand]) begin
            rr_found = 1'b1;
            rr_win   = PTR_W'(cand);
         end
      end
   end

   assign starve_hit = (STARVE_LIMIT != 0) && (starve_cnt_q == CNT_W'(STARVE_LIMIT));

   always_comb begin
      rr_gnt  = 1'b0;
      ch0_gnt = 1'b0;
      gnt     = '0;
      if (!reset_i) begin
         if (starve_hit && rr_found) rr_gnt  = 1'b1;
         else if (req_sel_i[0])      ch0_gnt = 1'b1;
         else if (rr_found)          rr_gnt  = 1'b1;
      end
      if (rr_gnt) gnt[rr_win] = 1'b1;
      gnt[0] = ch0_gnt;

      rr_ptr_d = rr_gnt ? rr_win : rr_ptr_q;

      starve_cnt_d = starve_cnt_q;
      if (!rr_found || rr_gnt)
         starve_cnt_d = '0;
      else if (ch0_gnt && !starve_hit && (starve_cnt_q != CNT_W'(STARVE_LIMIT)))
         starve_cnt_d = starve_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         rr_ptr_q     <= PTR_W'(NUM_CH - 1);
         starve_cnt_q <= '0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   always_comb begin
      mem_sel_o  = 1'b0;
      mem_wr_o   = 1'b0;
      mem_mask_o = '0;
      mem_addr_o = '0;
      mem_data_o = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (gnt[i]) begin
            mem_sel_o  = 1'b1;
            mem_wr_o   = req_wr_i[i];
            mem_mask_o = req_wr_i[i] ? req_mask_i[i*MASK_W +: MASK_W] : '0;
            mem_addr_o = req_addr_i[i*ADDR_W +: ADDR_W];
            mem_data_o = req_data_i[i*DATA_W +: DATA_W];
         end
      end
   end

   assign ack_o = gnt;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
      vram_arbiter_rd_lane #(.DATA_W(DATA_W)) u_lane (
         .clk        (clk),
         .reset_i    (reset_i),
         .rd_grant_i (gnt[g] & ~req_wr_i[g]),
         .mem_data_i (mem_data_i),
         .rd_valid_o (rd_valid_o[g]),
         .rd_data_o  (rd_data_o[g*DATA_W +: DATA_W])
      );
   end
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Parametrised single-port VRAM arbiter that sits between the video memory and multiple requesters (video generation, blitter, and further DMA-style channels). It generalises the previous fixed two-way split, where video always won and the blitter took leftovers, to NUM_CH channels. Channel 0 has fixed priority. Channels 1..NUM_CH-1 share the remaining slots round-robin, with a starvation guard that bounds how long channel 0 can lock them out. Each channel gets its own read-data capture register, and freshly returned data is bypassed straight through on the valid cycle.

## Interface
Parameters:
- NUM_CH, 4, number of requesting channels (2..8); channel 0 is the priority channel.
- ADDR_W, 16, VRAM word-address width.
- DATA_W, 16, VRAM data width (multiple of 4).
- STARVE_LIMIT, 8, number of consecutive channel-0 grants while a round-robin request is pending before the round-robin channel is forced through; 0 disables the guard.

Ports (vectors flattened; channel i occupies slice i):
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- req_sel_i  in  NUM_CH  per-channel access request.
- req_wr_i  in  NUM_CH  1 = write, 0 = read.
- req_mask_i  in  NUM_CH*DATA_W/4  per-channel nibble write masks.
- req_addr_i  in  NUM_CH*ADDR_W  per-channel word address.
- req_data_i  in  NUM_CH*DATA_W  per-channel write data.
- ack_o  out  NUM_CH  one-hot grant for the current cycle.
- rd_valid_o  out  NUM_CH  pulses when that channel's read data is on rd_data_o.
- rd_data_o  out  NUM_CH*DATA_W  per-channel read data.
- mem_sel_o  out  1  VRAM select.
- mem_wr_o  out  1  VRAM write enable.
- mem_mask_o  out  DATA_W/4  VRAM nibble mask.
- mem_addr_o  out  ADDR_W  VRAM address.
- mem_data_o  out  DATA_W  VRAM write data.
- mem_data_i  in  DATA_W  VRAM read data; valid 1 cycle after a read select.

## Operation
- Grant selection is combinational and yields at most one grant per cycle:
  - Forced grant: if starve_cnt == STARVE_LIMIT (guard enabled) and any round-robin channel requests, the round-robin winner gets the grant.
  - Otherwise, if req_sel_i[0] is high, channel 0 gets the grant.
  - Otherwise the round-robin winner gets the grant: search rr_ptr+1, rr_ptr+2, ... over 1..NUM_CH-1 with wrap (NUM_CH-1 wraps to 1), and take the first channel that is requesting.
- rr_ptr is a register, reset to NUM_CH-1 so that channel 1 is searched first. It updates to k whenever round-robin channel k is granted.
- starve_cnt (width clog2(STARVE_LIMIT+1)):
  - Resets to 0.
  - Increments when channel 0 is granted while any round-robin request is pending.
  - Clears to 0 on any round-robin grant, or in any cycle with no round-robin request.
  - Saturates at STARVE_LIMIT.
- The memory port mirrors the granted channel's wr/mask/addr/data, and mem_sel_o is asserted. With no grant: mem_sel_o=0, mem_wr_o=0, mem_mask_o=0, mem_addr_o=0, mem_data_o=0.
- mem_mask_o is forced to 0 on reads.
- Requests are not queued. A requester holds sel/wr/addr/data until it sees ack_o; dropping sel before ack withdraws the request with no side effect.
- Reads: a registered rd_pend[i] is set for the cycle after a read grant to channel i.
  - On that cycle, rd_valid_o[i]=1 and rd_data_o[i]=mem_data_i (bypass), and hold[i] captures mem_data_i.
  - At all other times rd_data_o[i]=hold[i].
- Writes never produce rd_valid_o.
- Back-to-back reads by one channel are legal. Each read returns on the cycle after its own grant.

## Timing
- Reset (async assert, sync-safe release): rr_ptr=NUM_CH-1, starve_cnt=0, rd_pend=0, hold=0.
  - Outputs while reset_i=1: ack_o=0, rd_valid_o=0, rd_data_o=0, and all mem_*_o=0. Grants are suppressed during reset.
- Grant and memory-port latency: 0 cycles (combinational from req_*).
- Read latency: data appears 1 cycle after ack_o on rd_data_o with rd_valid_o.
- Throughput: one access per cycle, sustained.
- Reset asserted while a read is outstanding: that rd_valid_o never pulses and hold clears to 0.
- NUM_CH=2: the round-robin degenerates to channel 1 only. The starvation guard still applies.
- Channel 0 requesting every cycle with the guard disabled: round-robin channels never win (legal, documented).

## Test plan
- Idle, then reset: hold reset_i=1 with all req_sel_i=1. Required: ack_o=0, mem_sel_o=0. After release, ack_o=4'b0001.
- Round-robin order: NUM_CH=4, channels 1..3 request continuously, channel 0 idle. Required grants: 1,2,3,1,2,3; mem_addr_o follows each granted channel's address.
- Starvation guard: STARVE_LIMIT=8, channels 0 and 2 request continuously. Required: eight channel-0 grants, then one channel-2 grant, repeating (period 9).
- Read return and hold:
  - Channel 1 reads addr 0x1234 while mem_data_i returns 0xBEEF the next cycle. Required: rd_valid_o[1]=1 for exactly one cycle with rd_data_o[1]=0xBEEF.
  - rd_data_o[1] stays 0xBEEF afterwards, even though mem_data_i changes.
- Masked write: channel 2 writes data 0xA5A5 with mask 4'b0101 to 0x00FF. Required in the same cycle: mem_wr_o=1, mem_mask_o=4'b0101, mem_data_o=0xA5A5, mem_addr_o=0x00FF. No rd_valid_o pulses.
- Reset mid-read: assert reset_i in the cycle after channel 3's read grant. Required: rd_valid_o[3] stays 0 and rd_data_o[3]=0.
